// File: rtl/mcycle_unit.sv
// -----------------------------------------------------------------------------
// mcycle_unit
//   Iterative unsigned multiplier / divider for the Execute stage. One
//   shift-add (MUL) or restoring-subtract (DIV) step per clock, WIDTH steps per
//   operation, fixed latency of WIDTH+1 cycles from Start to Done.
//
// Ports
//   CLK       in   1      clock, rising edge
//   ResetN    in   1      asynchronous active-low reset
//   Start     in   1      request, sampled only in IDLE
//   MCycleOp  in   1      0 = multiply, 1 = divide (latched with Start)
//   Operand1  in   WIDTH  multiplicand / dividend (latched with Start)
//   Operand2  in   WIDTH  multiplier / divisor (latched with Start)
//   Result1   out  WIDTH  MUL: product low half,  DIV: quotient
//   Result2   out  WIDTH  MUL: product high half, DIV: remainder
//   Busy      out  1      high while a request is accepted or computing
//   Done      out  1      one-cycle pulse, Result1/Result2 valid
//   DbgState  out  2      current FSM state (0 IDLE, 1 COMPUTE, 2 DONE)
//
// Handshake: a request is accepted in any cycle where the unit is in IDLE and
// Start=1; Busy rises combinationally in that same cycle so the front of the
// pipeline stalls immediately. Start is ignored while Busy or Done is high.
// Exactly one Done pulse follows each accepted request, WIDTH+1 cycles later;
// Result1/Result2 then hold until the next completion.
// -----------------------------------------------------------------------------
module mcycle_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             ResetN,
  input  logic             Start,
  input  logic             MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done,
  output logic [1:0]       DbgState
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_count;
  logic               r_op;

  // Multiply datapath: exact 2*WIDTH accumulator, multiplicand shifts left,
  // multiplier shifts right so bit 0 is always the current multiplier bit.
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;

  // Divide datapath: r_quot starts as the dividend; its MSB is shifted into
  // the remainder each step while the new quotient bit enters at the LSB.
  logic [WIDTH:0]     r_rem;
  logic [WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]   r_divisor;

  logic [2*WIDTH-1:0] w_acc_nx;
  logic [WIDTH+1:0]   w_rem_sh;
  logic [WIDTH+1:0]   w_diff;
  logic               w_sub_ok;
  logic [WIDTH:0]     w_rem_nx;
  logic [WIDTH-1:0]   w_quot_nx;

  always_comb begin
    w_acc_nx  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    w_rem_sh  = {r_rem, r_quot[WIDTH-1]};
    w_diff    = w_rem_sh - {2'b00, r_divisor};
    // Borrow out of the subtract means the trial remainder was too small.
    w_sub_ok  = ~w_diff[WIDTH+1];
    w_rem_nx  = w_sub_ok ? w_diff[WIDTH:0] : w_rem_sh[WIDTH:0];
    w_quot_nx = {r_quot[WIDTH-2:0], w_sub_ok};
  end

  // A zero divisor makes every trial subtract succeed, so the plain algorithm
  // already yields quotient = all ones and remainder = dividend.

  assign Busy     = ((r_state == S_IDLE) && Start) || (r_state == S_COMPUTE);
  assign DbgState = r_state;

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_op      <= 1'b0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_rem     <= '0;
      r_quot    <= '0;
      r_divisor <= '0;
      Result1   <= '0;
      Result2   <= '0;
      Done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            r_op      <= MCycleOp;
            r_count   <= '0;
            r_acc     <= '0;
            r_mcand   <= {{WIDTH{1'b0}}, Operand1};
            r_mplier  <= Operand2;
            r_rem     <= '0;
            r_quot    <= Operand1;
            r_divisor <= Operand2;
            r_state   <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          // Both datapaths step every cycle; r_op only picks the result.
          r_acc    <= w_acc_nx;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_rem    <= w_rem_nx;
          r_quot   <= w_quot_nx;
          if (r_count == CW'(WIDTH - 1)) begin
            if (r_op) begin
              Result1 <= w_quot_nx;
              Result2 <= w_rem_nx[WIDTH-1:0];
            end else begin
              Result1 <= w_acc_nx[WIDTH-1:0];
              Result2 <= w_acc_nx[2*WIDTH-1:WIDTH];
            end
            Done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        S_DONE: begin
          Done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          Done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcycle_unit.sv
module tb_mcycle_unit;

  localparam int W = 32;
  localparam int LAT = W + 1;

  logic         CLK;
  logic         ResetN;
  logic         Start;
  logic         MCycleOp;
  logic [W-1:0] Operand1;
  logic [W-1:0] Operand2;
  logic [W-1:0] Result1;
  logic [W-1:0] Result2;
  logic         Busy;
  logic         Done;
  logic [1:0]   DbgState;

  mcycle_unit #(.WIDTH(W)) dut (
    .CLK      (CLK),
    .ResetN   (ResetN),
    .Start    (Start),
    .MCycleOp (MCycleOp),
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .Result1  (Result1),
    .Result2  (Result2),
    .Busy     (Busy),
    .Done     (Done),
    .DbgState (DbgState)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [2*W-1:0] exp_q[$];      // {Result2, Result1}
  int             exp_cyc_q[$];  // cycle in which Done is due
  int             checks = 0;
  int             errors = 0;
  logic [W-1:0]   prev_r1 = '0;
  logic [W-1:0]   prev_r2 = '0;

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every Done pulse pops one expected result and its due cycle.
  always @(negedge CLK) begin
    if (ResetN && Done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [2*W-1:0] e;
        int ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        chk("results", {Result2, Result1}, e);
        chk("done_cycle", 64'(cyc), 64'(ec));
      end
    end
  end

  // ---------------- driver ----------------
  // Issues one operation; glitch_at > 0 re-pulses Start with other operands
  // at that cycle offset, which the unit must ignore.
  task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] e1, input logic [W-1:0] e2, input int glitch_at);
    int  busy_cnt;
    int  done_off;
    bit  seen;
    @(negedge CLK);
    Start    = 1'b1;
    MCycleOp = op;
    Operand1 = a;
    Operand2 = b;
    #1;
    exp_q.push_back({e2, e1});
    exp_cyc_q.push_back(cyc + LAT);
    chk("busy_in_request_cycle", 64'(Busy), 64'd1);
    busy_cnt = 0;
    done_off = -1;
    seen     = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      if (Busy) busy_cnt++;
      @(negedge CLK);
      // Scramble inputs after the request so only latched operands matter.
      Start    = (k + 1 == glitch_at);
      MCycleOp = ~op;
      Operand1 = $urandom();
      Operand2 = $urandom_range(1, 1000);
      #1;
      if (k + 1 == 5) begin
        chk("results_hold_during_compute", {Result2, Result1}, {prev_r2, prev_r1});
      end
      if (Done) begin
        seen     = 1'b1;
        done_off = k + 1;
      end
    end
    Start = 1'b0;
    if (!seen) begin
      chk("done_timeout", 64'd0, 64'd1);
    end else begin
      chk("done_offset", 64'(done_off), 64'(LAT));
      chk("busy_cycles", 64'(busy_cnt), 64'(LAT));
      chk("busy_low_in_done", 64'(Busy), 64'd0);
      @(negedge CLK);
      #1;
      chk("done_single_pulse", {63'd0, Done}, 64'd0);
      chk("results_hold_after_done", {Result2, Result1}, {e2, e1});
      chk("state_idle_after_done", 64'(DbgState), 64'd0);
    end
    prev_r1 = e1;
    prev_r2 = e2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ResetN   = 1'b0;
    Start    = 1'b0;
    MCycleOp = 1'b0;
    Operand1 = '0;
    Operand2 = '0;
    repeat (3) @(negedge CLK);
    #1;
    chk("reset_results", {Result2, Result1}, 64'd0);
    chk("reset_busy_done", {62'd0, Busy, Done}, 64'd0);
    chk("reset_state", 64'(DbgState), 64'd0);
    @(negedge CLK);
    ResetN = 1'b1;

    run_op(1'b0, 32'd7,          32'd6,          32'd42,         32'd0,          0);
    run_op(1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001,   32'hFFFFFFFE,   0);
    run_op(1'b0, 32'h00010000,   32'h00010000,   32'h00000000,   32'h00000001,   0);
    run_op(1'b1, 32'd100,        32'd7,          32'd14,         32'd2,          0);
    run_op(1'b1, 32'h80000000,   32'd1,          32'h80000000,   32'd0,          0);
    run_op(1'b1, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          0);
    run_op(1'b1, 32'hFFFFFFFF,   32'h00000010,   32'h0FFFFFFF,   32'h0000000F,   0);
    run_op(1'b0, 32'd3,          32'd3,          32'd9,          32'd0,          10);

    // Reset in the middle of a divide: everything clears at once.
    @(negedge CLK);
    Start    = 1'b1;
    MCycleOp = 1'b1;
    Operand1 = 32'd1000;
    Operand2 = 32'd3;
    @(negedge CLK);
    Start = 1'b0;
    repeat (11) @(negedge CLK);
    ResetN = 1'b0;
    #1;
    chk("midop_reset_busy_done", {62'd0, Busy, Done}, 64'd0);
    chk("midop_reset_results", {Result2, Result1}, 64'd0);
    chk("midop_reset_state", 64'(DbgState), 64'd0);
    @(negedge CLK);
    ResetN  = 1'b1;
    prev_r1 = '0;
    prev_r2 = '0;

    run_op(1'b0, 32'd2, 32'd5, 32'd10, 32'd0, 0);

    repeat (5) @(negedge CLK);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard bound on the whole run.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
